div_issue_arbiter: RTL and testbench

DIV_ISSUE_ARBITER -- requirements
Module: div_issue_arbiter

---
 rtl/div_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 39 +++
 rtl/div_issue_arbiter.sv | 144 ++++++++++++++
 tb/tb_div_issue_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the divider issue arbiter:
//                FSM state encoding, divide-by-zero fill value, index width
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

  // Issue FSM states, explicitly encoded in two bits.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } div_state_t;

  // Quotient reported for a zero divisor; consumers truncate to their width
  // (widest supported operand is DBZ_MAX_W bits).
  localparam int DBZ_MAX_W = 64;
  localparam logic [DBZ_MAX_W-1:0] DBZ_RESULT = '1;

  // Width of a thread index; a single thread still needs one bit to hold it.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin selector. Priority starts at the
//                thread after last_grant and wraps; output is one-hot (or
//                zero when nothing requests).
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int THREADS = 4,
  parameter int IDX_W   = 2
) (
  input  logic [THREADS-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [THREADS-1:0] grant
);

  logic found;

  // First pass covers threads above last_grant, second pass wraps to the rest.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int t = 0; t < THREADS; t++) begin
      if (!found && req[t] && (t > int'(last_grant))) begin
        grant[t] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int t = 0; t < THREADS; t++) begin
      if (!found && req[t] && (t <= int'(last_grant))) begin
        grant[t] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : div_issue_arbiter
//  Description : Shares one multi-cycle divider among THREADS requesters.
//                Round-robin grant, operand latch, divide-by-zero bypass and
//                one-hot response; one operation in flight at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_issue_arbiter
  import div_pkg::*;
#(
  parameter int N            = 8,
  parameter int THREADS      = 4,
  parameter int verbose_flag = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [THREADS-1:0]   req_valid,
  input  logic [THREADS*N-1:0] req_dividend,
  input  logic [THREADS*N-1:0] req_divisor,
  output logic [THREADS-1:0]   req_ready,
  output logic [THREADS-1:0]   resp_valid,
  output logic [N-1:0]         resp_result,
  output logic                 resp_dbz,
  output logic                 div_start,
  output logic [N-1:0]         div_dividend,
  output logic [N-1:0]         div_divisor,
  input  logic [N-1:0]         div_result,
  input  logic                 div_done
);

  localparam int IDX_W = idx_width(THREADS);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(THREADS - 1);

  div_state_t         state;
  logic [IDX_W-1:0]   last_grant;
  logic [THREADS-1:0] cur_grant;
  logic [THREADS-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [N-1:0]       sel_dividend;
  logic [N-1:0]       sel_divisor;

  rr_arbiter #(
    .THREADS (THREADS),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Encode the one-hot grant and steer the winner's operands.
  always_comb begin
    grant_idx    = '0;
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int t = 0; t < THREADS; t++) begin
      if (grant[t]) begin
        grant_idx    = IDX_W'(t);
        sel_dividend = req_dividend[t*N +: N];
        sel_divisor  = req_divisor[t*N +: N];
      end
    end
  end

  // Issue FSM; every output is registered and asserted for the state it
  // leads into: req_ready during ISSUE, div_start on the first WAIT cycle,
  // resp_* during RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      last_grant   <= LAST_INIT;
      cur_grant    <= '0;
      req_ready    <= '0;
      resp_valid   <= '0;
      resp_result  <= '0;
      resp_dbz     <= 1'b0;
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      req_ready   <= '0;
      resp_valid  <= '0;
      resp_result <= '0;
      resp_dbz    <= 1'b0;
      div_start   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            req_ready    <= grant;
            cur_grant    <= grant;
            last_grant   <= grant_idx;
            div_dividend <= sel_dividend;
            div_divisor  <= sel_divisor;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // A zero divisor never reaches the divider.
          if (div_divisor == '0) begin
            resp_valid  <= cur_grant;
            resp_result <= N'(DBZ_RESULT);
            resp_dbz    <= 1'b1;
            state       <= ST_RESP;
          end else begin
            div_start <= 1'b1;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (div_done) begin
            resp_valid  <= cur_grant;
            resp_result <= div_result;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  generate
    if (verbose_flag != 0) begin : g_verbose
`ifndef SYNTHESIS
      // Trace each accepted request and each delivered response.
      always @(posedge clk) begin
        if (!reset && (req_ready != '0))
          $display("div_issue_arbiter: grant %b dividend %0d divisor %0d",
                   req_ready, div_dividend, div_divisor);
        if (!reset && (resp_valid != '0))
          $display("div_issue_arbiter: resp %b result %0d dbz %0b",
                   resp_valid, resp_result, resp_dbz);
      end
`endif
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_div_issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_issue_arbiter
//  Description : Self-checking bench for div_issue_arbiter with a behavioural
//                variable-latency divider; table vectors plus hand sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_issue_arbiter;

  localparam int N = 8;
  localparam int T = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [T-1:0]   req_valid;
  logic [T*N-1:0] req_dividend;
  logic [T*N-1:0] req_divisor;
  logic [T-1:0]   req_ready;
  logic [T-1:0]   resp_valid;
  logic [N-1:0]   resp_result;
  logic           resp_dbz;
  logic           div_start;
  logic [N-1:0]   div_dividend;
  logic [N-1:0]   div_divisor;
  logic [N-1:0]   div_result;
  logic           div_done;

  // divider model state
  logic           mdl_done;
  logic           mdl_busy;
  logic [N-1:0]   cap_a;
  logic [N-1:0]   cap_b;
  int             mdl_cnt;
  logic           mdl_hold;
  int             mdl_lat;
  logic           stray_done;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cyc = -1;
  int n_starts = 0;
  int exp_starts = 0;
  int bad_idle = 0;
  int bad_onehot = 0;
  int bad_stable = 0;

  assign div_done = mdl_done | stray_done;

  div_issue_arbiter #(.N(N), .THREADS(T), .verbose_flag(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_result  (resp_result),
    .resp_dbz     (resp_dbz),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_result   (div_result),
    .div_done     (div_done)
  );

  always #5 clk = ~clk;

  // cycle counter; remembers the cycle in which div_done was seen high
  always @(posedge clk) begin
    if (div_done) done_cyc = cyc;
    cyc = cyc + 1;
  end

  // behavioural divider: start -> mdl_lat extra cycles -> one-cycle done
  always @(posedge clk) begin
    if (reset) begin
      mdl_busy   <= 1'b0;
      mdl_done   <= 1'b0;
      div_result <= 8'h5A;
    end else begin
      mdl_done   <= 1'b0;
      div_result <= 8'h5A;
      if (mdl_busy) begin
        if (div_dividend !== cap_a || div_divisor !== cap_b) bad_stable = bad_stable + 1;
        if (!mdl_hold) begin
          if (mdl_cnt == 0) begin
            mdl_done   <= 1'b1;
            div_result <= (cap_b == 0) ? 8'h00 : cap_a / cap_b;
            mdl_busy   <= 1'b0;
          end else begin
            mdl_cnt <= mdl_cnt - 1;
          end
        end
      end
      if (div_start) begin
        mdl_busy <= 1'b1;
        cap_a    <= div_dividend;
        cap_b    <= div_divisor;
        mdl_cnt  <= mdl_lat;
        n_starts = n_starts + 1;
      end
    end
  end

  // continuous output sanity: zero payload when idle, one-hot pulses
  always @(negedge clk) begin
    if (!reset) begin
      if (resp_valid == '0 && (resp_result != '0 || resp_dbz)) bad_idle = bad_idle + 1;
      if ($countones(resp_valid) > 1 || $countones(req_ready) > 1) bad_onehot = bad_onehot + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int w;
    w = 0;
    while (req_ready == '0 && w < budget) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic wait_resp(input int budget);
    int w;
    w = 0;
    while (resp_valid == '0 && w < budget) begin
      @(negedge clk);
      w++;
    end
  endtask

  // One request from a lone thread, with latency and payload checks.
  task automatic run_op(input int th, input logic [7:0] dvd, input logic [7:0] dvs,
                        input logic [7:0] exp_q, input logic exp_dbz);
    logic [T-1:0] oh;
    int t_grant;
    oh = T'(1) << th;
    req_dividend[th*N +: N] = dvd;
    req_divisor[th*N +: N]  = dvs;
    req_valid = oh;
    wait_ready(20);
    check("grant", 32'(req_ready), 32'(oh));
    if (req_ready == '0) begin
      req_valid = '0;
      return;
    end
    t_grant   = cyc;
    req_valid = '0;
    @(negedge clk);
    check("div_start", 32'(div_start), 32'(!exp_dbz));
    if (!exp_dbz) begin
      exp_starts++;
      wait_resp(50);
      check("resp_lat", 32'(cyc), 32'(done_cyc + 1));
    end else begin
      check("dbz_lat", 32'(cyc), 32'(t_grant + 1));
    end
    check("resp_valid", 32'(resp_valid), 32'(oh));
    check("resp_result", 32'(resp_result), 32'(exp_q));
    check("resp_dbz", 32'(resp_dbz), 32'(exp_dbz));
    @(negedge clk);
    check("resp_pulse", 32'(resp_valid), 32'h0);
  endtask

  typedef struct {
    int         th;
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic [7:0] q;
    logic       dbz;
  } vec_t;

  vec_t vt[8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  fq[4];
    logic        fz[4];
    logic [31:0] acc;
    int          th;

    reset = 1'b1; req_valid = '0; req_dividend = '0; req_divisor = '0;
    stray_done = 1'b0; mdl_hold = 1'b0; mdl_lat = 1;

    vt[0] = '{2, 8'd200, 8'd7,   8'd28,  1'b0};
    vt[1] = '{1, 8'd45,  8'd0,   8'hFF,  1'b1};
    vt[2] = '{0, 8'd255, 8'd1,   8'd255, 1'b0};
    vt[3] = '{3, 8'd0,   8'd5,   8'd0,   1'b0};
    vt[4] = '{0, 8'd7,   8'd9,   8'd0,   1'b0};
    vt[5] = '{3, 8'd255, 8'd255, 8'd1,   1'b0};
    vt[6] = '{2, 8'd0,   8'd0,   8'hFF,  1'b1};
    vt[7] = '{1, 8'd100, 8'd10,  8'd10,  1'b0};

    // reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({req_ready, resp_valid, resp_result, resp_dbz,
                                div_start}) | 32'({div_dividend, div_divisor}), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // table vectors
    for (int i = 0; i < 8; i++) begin
      mdl_lat = i % 4;
      run_op(vt[i].th, vt[i].dvd, vt[i].dvs, vt[i].q, vt[i].dbz);
    end

    // stray div_done in IDLE
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    acc = 0;
    repeat (4) begin
      acc = acc | 32'(resp_valid) | 32'(req_ready) | 32'(div_start);
      @(negedge clk);
    end
    check("stray_done_quiet", acc, 32'h0);
    mdl_lat = 2;
    run_op(0, 8'd60, 8'd4, 8'd15, 1'b0);

    // fairness: all threads request continuously after reset
    do_reset();
    fq[0] = 8'd10; fz[0] = 1'b0; req_dividend[0*N +: N] = 8'd90;  req_divisor[0*N +: N] = 8'd9;
    fq[1] = 8'd11; fz[1] = 1'b0; req_dividend[1*N +: N] = 8'd77;  req_divisor[1*N +: N] = 8'd7;
    fq[2] = 8'd15; fz[2] = 1'b0; req_dividend[2*N +: N] = 8'd255; req_divisor[2*N +: N] = 8'd16;
    fq[3] = 8'hFF; fz[3] = 1'b1; req_dividend[3*N +: N] = 8'd12;  req_divisor[3*N +: N] = 8'd0;
    mdl_lat = 1;
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      th = k % 4;
      wait_ready(20);
      check("fair_grant", 32'(req_ready), 32'(T'(1) << th));
      if (!fz[th]) exp_starts++;
      @(negedge clk);
      wait_resp(50);
      check("fair_resp_valid", 32'(resp_valid), 32'(T'(1) << th));
      check("fair_result", 32'(resp_result), 32'(fq[th]));
      check("fair_dbz", 32'(resp_dbz), 32'(fz[th]));
      @(negedge clk);
    end
    req_valid = '0;
    repeat (3) @(negedge clk);

    // reset while WAITing on a stalled divider
    mdl_hold = 1'b1;
    req_dividend[1*N +: N] = 8'd50; req_divisor[1*N +: N] = 8'd5;
    req_valid = 4'b0010;
    wait_ready(20);
    check("mid_grant", 32'(req_ready), 32'h2);
    req_valid = '0;
    exp_starts++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_outputs", 32'({req_ready, resp_valid, resp_result, resp_dbz,
                                    div_start}) | 32'({div_dividend, div_divisor}), 32'h0);
    reset = 1'b0;
    mdl_hold = 1'b0;
    acc = 0;
    repeat (5) begin
      @(negedge clk);
      acc = acc | 32'(resp_valid);
    end
    check("mid_reset_no_resp", acc, 32'h0);
    req_dividend[0*N +: N] = 8'd81; req_divisor[0*N +: N] = 8'd9;
    req_dividend[3*N +: N] = 8'd33; req_divisor[3*N +: N] = 8'd3;
    req_valid = 4'b1001;
    wait_ready(20);
    check("post_reset_grant", 32'(req_ready), 32'h1);
    req_valid = '0;
    exp_starts++;
    @(negedge clk);
    wait_resp(50);
    check("post_reset_resp", 32'(resp_valid), 32'h1);
    check("post_reset_result", 32'(resp_result), 32'd9);
    @(negedge clk);

    // data sweep through the divider model
    for (int a = 0; a < 256; a += 51) begin
      for (int b = 1; b < 256; b++) begin
        mdl_lat = b % 3;
        run_op(b % 4, 8'(a), 8'(b), 8'(a / b), 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    check("start_count", 32'(n_starts), 32'(exp_starts));
    check("idle_payload_zero", 32'(bad_idle), 32'h0);
    check("onehot_outputs", 32'(bad_onehot), 32'h0);
    check("operands_stable", 32'(bad_stable), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
